// File: rtl/fwd_hazard_tracker_if.sv
// ID/EX hazard-tracking bus: ID-stage instruction fields in, stall and EX forward selects out.
// master = pipeline control side, slave = fwd_hazard_tracker.
interface fwd_hazard_tracker_if #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned DEPTH   = 3
);
    localparam int unsigned SEL_W = $clog2(DEPTH);

    logic                     id_valid;
    logic                     id_reg_write;
    logic                     id_is_load;
    logic [REG_W-1:0]         id_rd;
    logic [NUM_SRC*REG_W-1:0] id_src;
    logic                     flush;
    logic                     stall;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic                     ex_valid;

    modport master (
        output id_valid, id_reg_write, id_is_load, id_rd, id_src, flush,
        input  stall, fwd_sel, ex_valid
    );

    modport slave (
        input  id_valid, id_reg_write, id_is_load, id_rd, id_src, flush,
        output stall, fwd_sel, ex_valid
    );
endinterface

// File: rtl/fwd_hazard_tracker.sv
// Tracks in-flight writers through DEPTH post-ID stages; drives EX forward selects and ID load-use
// stall. Define HAZARD_STATS_EN to add saturating stall_cycles / fwd_events counters.
module fwd_hazard_tracker #(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    fwd_hazard_tracker_if.slave bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] fwd_events
`endif
);
    localparam int unsigned SEL_W = $clog2(DEPTH);
    localparam logic [REG_W-1:0] ZeroReg = REG_W'(ZERO_REG);

    logic [DEPTH-1:0]         valid_q;
    logic [DEPTH-1:0]         rw_q;
    logic [DEPTH-1:0]         ld_q;
    logic [REG_W-1:0]         rd_q  [DEPTH];
    logic [REG_W-1:0]         src_q [NUM_SRC];
    logic [DEPTH-1:0]         eff;
    logic                     stall_hit;
    logic                     stall;
    logic                     load_id;
    logic [NUM_SRC*SEL_W-1:0] sel;

    always_comb begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
            eff[j] = valid_q[j] && rw_q[j] && (rd_q[j] != ZeroReg);
        end
    end

    // Scan oldest to youngest so the youngest matching writer overrides.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned j = DEPTH - 1; j >= 1; j--) begin
                if (valid_q[0] && eff[j] && (rd_q[j] == src_q[i])) begin
                    sel[i*SEL_W +: SEL_W] = SEL_W'(j);
                end
            end
        end
    end

    // Only loads younger than LOAD_LAT stages have data that cannot yet be forwarded.
    always_comb begin
        stall_hit = 1'b0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if ((j < LOAD_LAT) && eff[j] && ld_q[j] &&
                    (rd_q[j] == bus.id_src[i*REG_W +: REG_W])) begin
                    stall_hit = 1'b1;
                end
            end
        end
    end

    assign stall        = bus.id_valid && !bus.flush && stall_hit;
    assign load_id      = bus.id_valid && !stall && !bus.flush;
    assign bus.stall    = stall;
    assign bus.fwd_sel  = sel;
    assign bus.ex_valid = valid_q[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            rw_q    <= '0;
            ld_q    <= '0;
        end else begin
            valid_q <= {valid_q[DEPTH-2:0], load_id};
            rw_q    <= {rw_q[DEPTH-2:0], load_id && bus.id_reg_write};
            ld_q    <= {ld_q[DEPTH-2:0], load_id && bus.id_is_load};
        end
    end

    // Tags are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        rd_q[0] <= bus.id_rd;
        for (int unsigned j = 1; j < DEPTH; j++) begin
            rd_q[j] <= rd_q[j-1];
        end
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src_q[i] <= bus.id_src[i*REG_W +: REG_W];
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] n_fwd;
    logic [32:0] fe_sum;

    always_comb begin
        n_fwd = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (valid_q[0] && (sel[i*SEL_W +: SEL_W] != '0)) begin
                n_fwd = n_fwd + 32'd1;
            end
        end
        fe_sum = {1'b0, fwd_events} + {1'b0, n_fwd};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            fwd_events   <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            fwd_events <= fe_sum[32] ? '1 : fe_sum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Directed-vector bench for fwd_hazard_tracker: default instance (DEPTH=3, LOAD_LAT=1) and a
// DEPTH=4, LOAD_LAT=2 instance, each checked every cycle against an age-indexed history model.
module tb_fwd_hazard_tracker;
    typedef struct packed {
        logic       rst;
        logic       v;
        logic       rw;
        logic       ld;
        logic       fl;
        logic [4:0] rd;
        logic [4:0] s0;
        logic [4:0] s1;
    } vec_t;

    typedef struct packed {
        logic       v;
        logic       rw;
        logic       ld;
        logic [4:0] rd;
        logic [4:0] s0;
        logic [4:0] s1;
    } ent_t;

    // hist[a] = instruction that entered EX a cycles ago (a=0 is the one in EX now).
    typedef ent_t [7:0] hist_t;

    localparam int NCYC = 24;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    fwd_hazard_tracker_if #(.NUM_SRC(2), .REG_W(5), .DEPTH(3)) bus_a ();
    fwd_hazard_tracker_if #(.NUM_SRC(2), .REG_W(5), .DEPTH(4)) bus_b ();

`ifdef HAZARD_STATS_EN
    logic [31:0] sc_a, fe_a, sc_b, fe_b;
`endif

    fwd_hazard_tracker #(.DEPTH(3), .LOAD_LAT(1)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles (sc_a),
        .fwd_events   (fe_a)
`endif
    );

    fwd_hazard_tracker #(.DEPTH(4), .LOAD_LAT(2)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles (sc_b),
        .fwd_events   (fe_b)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;

    vec_t va [NCYC];
    vec_t vb [NCYC];

    function automatic vec_t mk(input bit rst, input bit v, input bit rw, input bit ld,
                                input bit fl, input int rd, input int s0, input int s1);
        vec_t x;
        x.rst = rst; x.v = v; x.rw = rw; x.ld = ld; x.fl = fl;
        x.rd = 5'(rd); x.s0 = 5'(s0); x.s1 = 5'(s1);
        return x;
    endfunction

    function automatic int m_sel(input hist_t h, input int depth, input logic [4:0] src);
        if (!h[0].v) return 0;
        for (int a = 1; a < depth; a++) begin
            if (h[a].v && h[a].rw && h[a].rd != 5'd31 && h[a].rd == src) return a;
        end
        return 0;
    endfunction

    function automatic logic [3:0] m_fwd(input hist_t h, input int depth);
        int s0;
        int s1;
        s0 = m_sel(h, depth, h[0].s0);
        s1 = m_sel(h, depth, h[0].s1);
        return {s1[1:0], s0[1:0]};
    endfunction

    function automatic int m_nfwd(input hist_t h, input int depth);
        return ((m_sel(h, depth, h[0].s0) != 0) ? 1 : 0) + ((m_sel(h, depth, h[0].s1) != 0) ? 1 : 0);
    endfunction

    function automatic bit m_stall(input hist_t h, input int lat, input vec_t x);
        if (!x.v || x.fl) return 1'b0;
        for (int a = 0; a < lat; a++) begin
            if (h[a].v && h[a].rw && h[a].ld && h[a].rd != 5'd31 &&
                (h[a].rd == x.s0 || h[a].rd == x.s1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic hist_t m_step(input hist_t h, input vec_t x, input bit st);
        ent_t e;
        e = '0;
        if (x.v && !st && !x.fl) begin
            e.v = 1'b1; e.rw = x.rw; e.ld = x.ld; e.rd = x.rd; e.s0 = x.s0; e.s1 = x.s1;
        end
        return {h[6:0], e};
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    task automatic drive(input vec_t a, input vec_t b);
        rst_a = a.rst;
        bus_a.id_valid = a.v; bus_a.id_reg_write = a.rw; bus_a.id_is_load = a.ld;
        bus_a.flush = a.fl; bus_a.id_rd = a.rd; bus_a.id_src = {a.s1, a.s0};
        rst_b = b.rst;
        bus_b.id_valid = b.v; bus_b.id_reg_write = b.rw; bus_b.id_is_load = b.ld;
        bus_b.flush = b.fl; bus_b.id_rd = b.rd; bus_b.id_src = {b.s1, b.s0};
    endtask

    hist_t   ha, hb;
    bit      known_a, known_b;
    bit      st_a, st_b;
    longint  msc_a, mfe_a, msc_b, mfe_b;

    initial begin
        for (int k = 0; k < NCYC; k++) begin
            va[k] = mk(0, 0, 0, 0, 0, 0, 0, 0);
            vb[k] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        end
        va[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
        va[1]  = mk(0, 1, 1, 0, 0, 1, 2, 3);    // ADD X1
        va[2]  = mk(0, 1, 1, 0, 0, 2, 1, 3);    // SUB X2,X1,X3
        va[4]  = mk(0, 1, 1, 0, 0, 1, 5, 6);    // X1 (will be WB)
        va[5]  = mk(0, 1, 1, 0, 0, 1, 6, 5);    // X1 (will be MEM)
        va[6]  = mk(0, 1, 1, 0, 0, 11, 1, 8);   // reads X1
        va[7]  = mk(0, 1, 1, 0, 0, 31, 2, 2);   // writes X31
        va[8]  = mk(0, 1, 1, 0, 0, 12, 31, 31); // reads X31
        va[9]  = mk(0, 1, 1, 0, 0, 9, 2, 3);
        va[10] = mk(0, 1, 1, 0, 0, 10, 2, 3);
        va[11] = mk(0, 1, 1, 0, 0, 13, 9, 10);  // X9 from WB, X10 from MEM
        va[12] = mk(0, 1, 1, 1, 0, 4, 5, 5);    // LDUR X4
        va[13] = mk(0, 1, 1, 0, 0, 5, 4, 4);    // ADD X5,X4,X4
        va[14] = mk(0, 1, 1, 0, 0, 5, 4, 4);    // held by stall
        va[16] = mk(0, 1, 1, 1, 0, 6, 2, 3);    // load X6
        va[17] = mk(0, 1, 1, 0, 1, 14, 6, 6);   // consumer flushed
        va[19] = mk(0, 1, 1, 1, 0, 7, 2, 3);    // load X7
        va[20] = mk(1, 1, 1, 0, 0, 15, 7, 7);   // consumer, reset mid-stall
        va[21] = mk(0, 1, 1, 0, 0, 15, 7, 7);

        vb[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
        vb[1]  = mk(0, 1, 1, 1, 0, 7, 1, 2);    // load X7
        vb[2]  = mk(0, 1, 1, 0, 0, 8, 7, 3);
        vb[3]  = mk(0, 1, 1, 0, 0, 8, 7, 3);
        vb[4]  = mk(0, 1, 1, 0, 0, 8, 7, 3);
        vb[6]  = mk(0, 1, 1, 0, 0, 3, 1, 2);
        vb[7]  = mk(0, 1, 1, 0, 0, 9, 3, 3);

        ha = '0; hb = '0; known_a = 0; known_b = 0;
        msc_a = 0; mfe_a = 0; msc_b = 0; mfe_b = 0;
        drive(va[0], vb[0]);
        @(posedge clk);
        #1;
        for (int k = 0; k < NCYC; k++) begin
            drive(va[k], vb[k]);
            @(negedge clk);
            st_a = m_stall(ha, 1, va[k]);
            st_b = m_stall(hb, 2, vb[k]);
            if (known_a) begin
                chk("a_stall", k, 32'(bus_a.stall), 32'(st_a));
                chk("a_ex_valid", k, 32'(bus_a.ex_valid), 32'(ha[0].v));
                chk("a_fwd_sel", k, 32'(bus_a.fwd_sel), 32'(m_fwd(ha, 3)));
`ifdef HAZARD_STATS_EN
                chk("a_stall_cycles", k, sc_a, 32'(msc_a));
                chk("a_fwd_events", k, fe_a, 32'(mfe_a));
`endif
            end
            if (known_b) begin
                chk("b_stall", k, 32'(bus_b.stall), 32'(st_b));
                chk("b_ex_valid", k, 32'(bus_b.ex_valid), 32'(hb[0].v));
                chk("b_fwd_sel", k, 32'(bus_b.fwd_sel), 32'(m_fwd(hb, 4)));
`ifdef HAZARD_STATS_EN
                chk("b_stall_cycles", k, sc_b, 32'(msc_b));
                chk("b_fwd_events", k, fe_b, 32'(mfe_b));
`endif
            end

            // Hand-computed anchors for the directed scenarios.
            case (k)
                1: begin
                    chk("lit_a_reset_stall", k, 32'(bus_a.stall), 32'd0);
                    chk("lit_a_reset_exv", k, 32'(bus_a.ex_valid), 32'd0);
                    chk("lit_a_reset_fwd", k, 32'(bus_a.fwd_sel), 32'h0);
                    chk("lit_b_reset_exv", k, 32'(bus_b.ex_valid), 32'd0);
                    chk("lit_b_load_fwd", k, 32'(bus_b.fwd_sel), 32'h0);
                end
                2: chk("lit_b_stall1", k, 32'(bus_b.stall), 32'd1);
                3: begin
                    chk("lit_a_b2b_fwd", k, 32'(bus_a.fwd_sel), 32'h1);
                    chk("lit_b_stall2", k, 32'(bus_b.stall), 32'd1);
                end
                4: begin
                    chk("lit_b_release", k, 32'(bus_b.stall), 32'd0);
                    chk("lit_b_bubble", k, 32'(bus_b.ex_valid), 32'd0);
                end
                5: chk("lit_b_fwd3", k, 32'(bus_b.fwd_sel), 32'h3);
                7: chk("lit_a_youngest", k, 32'(bus_a.fwd_sel), 32'h1);
                8: chk("lit_b_b2b_fwd", k, 32'(bus_b.fwd_sel), 32'h5);
                9: chk("lit_a_x31", k, 32'(bus_a.fwd_sel), 32'h0);
                12: chk("lit_a_wb_mem", k, 32'(bus_a.fwd_sel), 32'h6);
                13: chk("lit_a_lu_stall", k, 32'(bus_a.stall), 32'd1);
                14: begin
                    chk("lit_a_lu_release", k, 32'(bus_a.stall), 32'd0);
                    chk("lit_a_lu_bubble", k, 32'(bus_a.ex_valid), 32'd0);
                end
                15: chk("lit_a_lu_fwd", k, 32'(bus_a.fwd_sel), 32'hA);
`ifdef HAZARD_STATS_EN
                16: begin
                    chk("lit_a_stall_cycles", k, sc_a, 32'd1);
                    chk("lit_a_fwd_events", k, fe_a, 32'd6);
                end
`endif
                17: chk("lit_a_flush_stall", k, 32'(bus_a.stall), 32'd0);
                18: chk("lit_a_flush_bubble", k, 32'(bus_a.ex_valid), 32'd0);
                20: chk("lit_a_pre_reset_stall", k, 32'(bus_a.stall), 32'd1);
                21: begin
                    chk("lit_a_post_reset_stall", k, 32'(bus_a.stall), 32'd0);
                    chk("lit_a_post_reset_exv", k, 32'(bus_a.ex_valid), 32'd0);
                    chk("lit_a_post_reset_fwd", k, 32'(bus_a.fwd_sel), 32'h0);
                end
                default: ;
            endcase

            @(posedge clk);
            if (va[k].rst) begin
                ha = '0; known_a = 1; msc_a = 0; mfe_a = 0;
            end else begin
                msc_a = msc_a + (st_a ? 1 : 0);
                mfe_a = mfe_a + m_nfwd(ha, 3);
                ha = m_step(ha, va[k], st_a);
            end
            if (vb[k].rst) begin
                hb = '0; known_b = 1; msc_b = 0; mfe_b = 0;
            end else begin
                msc_b = msc_b + (st_b ? 1 : 0);
                mfe_b = mfe_b + m_nfwd(hb, 4);
                hb = m_step(hb, vb[k], st_b);
            end
            #1;
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
